// File: rtl/accum8_stage.sv
// accum8_stage: handshake-driven add/subtract accumulator with sticky carry/overflow flags and a saturating operand counter
//
// Optional feature macro: ACCUM8_SATURATE_EN
//   defined   -> signed saturating arithmetic (SUM clamps on signed overflow)
//   undefined -> SUM wraps modulo 2^W, no clamping logic
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   operand on in_data_i/sub_i is valid
//   in_data_i    W-bit operand
//   sub_i        1 = subtract operand, 0 = add operand
//   clr_i        synchronous clear of sum, flags, count and state (highest priority)
//   in_ready_o   stage accepts an operand this cycle (decoded from state only)
//   sum_o        running sum
//   sum_valid_o  one-cycle pulse after sum_o is updated
//   carry_o      sticky carry-out (add) / borrow (sub)
//   ovf_o        sticky two's-complement overflow
//   count_o      operands accepted since reset/clear, saturating
module accum8_stage #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [W-1:0]  in_data_i,
    input  logic          sub_i,
    input  logic          clr_i,
    output logic          in_ready_o,
    output logic [W-1:0]  sum_o,
    output logic          sum_valid_o,
    output logic          carry_o,
    output logic          ovf_o,
    output logic [CW-1:0] count_o
);
    typedef enum logic {IDLE, EXEC} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic          sub_q, sub_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          sum_valid_q, sum_valid_d;
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] count_q, count_d;

    logic [W:0]    add_ext;
    logic [W-1:0]  b_eff;
    logic [W-1:0]  res_raw;
    logic [W-1:0]  res;
    logic          cy;
    logic          ov;

    always_comb begin
        add_ext = {1'b0, sum_q} + {1'b0, opnd_q};
        res_raw = sub_q ? sum_q - opnd_q : add_ext[W-1:0];
        cy      = sub_q ? (sum_q < opnd_q) : add_ext[W];
        // Effective second operand: negated for subtraction, used only for the overflow sign test.
        b_eff   = sub_q ? -opnd_q : opnd_q;
        ov      = (sum_q[W-1] == b_eff[W-1]) && (res_raw[W-1] != sum_q[W-1]);
`ifdef ACCUM8_SATURATE_EN
        // Overflow direction follows the sign of the accumulator operand.
        res     = ov ? (sum_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : res_raw;
`else
        res     = res_raw;
`endif
    end

    always_comb begin
        state_d     = state_q;
        opnd_d      = opnd_q;
        sub_d       = sub_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        count_d     = count_q;
        if (clr_i) begin
            state_d = IDLE;
            sum_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else if (state_q == EXEC) begin
            state_d     = IDLE;
            sum_d       = res;
            sum_valid_d = 1'b1;
            carry_d     = carry_q | cy;
            ovf_d       = ovf_q | ov;
        end else if (in_valid_i) begin
            state_d = EXEC;
            opnd_d  = in_data_i;
            sub_d   = sub_i;
            count_d = (&count_q) ? count_q : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opnd_q      <= '0;
            sub_q       <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            sub_q       <= sub_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign sum_o       = sum_q;
    assign sum_valid_o = sum_valid_q;
    assign carry_o     = carry_q;
    assign ovf_o       = ovf_q;
    assign count_o     = count_q;
endmodule
